// File: rtl/dpram_pkg.sv
// Shared constants for the parametrised dual-port scratch RAM.
// Covers the collision-mode selectors and the clear/run state encoding.
package dpram_pkg;

  localparam int RD_WRITE_FIRST = 0;
  localparam int RD_READ_FIRST  = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once, writing the init value,
// then hands the memory to the user ports and drops busy.
module ram_clear_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_e            state_r;
  state_e            state_next_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              busy_r;
  logic              last_s;

  assign last_s = (cnt_r == {ADDR_W{1'b1}});

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic: leave CLEAR once the top word has been written
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLEAR: begin
        if (last_s) state_next_s = RUN;
        else        state_next_s = CLEAR;
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = CLEAR;
    endcase
  end

  // clear address counter and registered busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      busy_r <= 1'b1;
    end else if (state_r == CLEAR) begin
      cnt_r  <= cnt_r + 1'b1;
      busy_r <= !last_s;
    end else begin
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end
  end

  // output logic: no clear write while reset is still held
  always_comb begin
    clr_we = 1'b0;
    case (state_r)
      CLEAR: begin
        if (rst) clr_we = 1'b0;
        else     clr_we = 1'b1;
      end
      RUN:     clr_we = 1'b0;
      default: clr_we = 1'b0;
    endcase
  end

  assign clr_addr = cnt_r;
  assign busy     = busy_r;

endmodule

// File: rtl/dual_port_sync_ram_param.sv
// Single-clock one-write/one-read scratch RAM with registered read, valid strobe,
// selectable same-address collision behaviour and a hardware clear after reset.
module dual_port_sync_ram_param
  import dpram_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               ADDR_W   = 3,
  parameter int               RD_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] data_r,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              wr_go_s;
  logic              rd_go_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_din_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] data_r_r;
  logic              rd_valid_r;

  ram_clear_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clear (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy_s),
    .clr_we  (clr_we_s),
    .clr_addr(clr_addr_s)
  );

  // user requests are dropped while busy or while reset is asserted
  assign wr_go_s = we && !busy_s && !rst;
  assign rd_go_s = en && !busy_s && !rst;

  // single memory write port shared by the clear sequencer and the user
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = addr_w;
    mem_din_s  = data_w;
    if (clr_we_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = clr_addr_s;
      mem_din_s  = INIT_VAL;
    end else begin
      mem_we_s   = wr_go_s;
      mem_addr_s = addr_w;
      mem_din_s  = data_w;
    end
  end

  // memory array, deliberately without reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_din_s;
    end
  end

  // read word select; the array read returns pre-edge contents (read-first)
  always_comb begin
    rd_word_s = mem_r[addr_r];
    if ((RD_MODE == RD_WRITE_FIRST) && wr_go_s && (addr_w == addr_r)) begin
      rd_word_s = data_w;
    end else begin
      rd_word_s = mem_r[addr_r];
    end
  end

  // registered read data and one-cycle valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r_r   <= '0;
      rd_valid_r <= 1'b0;
    end else if (rd_go_s) begin
      data_r_r   <= rd_word_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign data_r   = data_r_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_s;

endmodule

// File: tb/tb_dual_port_sync_ram_param.sv
// Bench: three RAM instances (write-first, read-first, 32x32) checked every cycle
// against an array-based reference model, plus hand-computed scenario checks.
module tb_dual_port_sync_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // group A drives both 16x8 instances; group B drives the 32-bit x 32-word one
  logic        rst_a, we_a, en_a;
  logic [2:0]  aw_a, ar_a;
  logic [15:0] dw_a;
  logic        rst_b, we_b, en_b;
  logic [4:0]  aw_b, ar_b;
  logic [31:0] dw_b;

  logic [15:0] d0, d1;
  logic [31:0] d2;
  logic        v0, v1, v2, b0, b1, b2;

  int total = 0;
  int bad   = 0;

  dual_port_sync_ram_param #(.DATA_W(16), .ADDR_W(3), .RD_MODE(0), .INIT_VAL(16'hA5A5)) u0 (
    .clk(clk), .rst(rst_a), .we(we_a), .addr_w(aw_a), .data_w(dw_a),
    .en(en_a), .addr_r(ar_a), .data_r(d0), .rd_valid(v0), .busy(b0));
  dual_port_sync_ram_param #(.DATA_W(16), .ADDR_W(3), .RD_MODE(1), .INIT_VAL(16'hA5A5)) u1 (
    .clk(clk), .rst(rst_a), .we(we_a), .addr_w(aw_a), .data_w(dw_a),
    .en(en_a), .addr_r(ar_a), .data_r(d1), .rd_valid(v1), .busy(b1));
  dual_port_sync_ram_param #(.DATA_W(32), .ADDR_W(5), .RD_MODE(0), .INIT_VAL(32'h5A5A0F0F)) u2 (
    .clk(clk), .rst(rst_b), .we(we_b), .addr_w(aw_b), .data_w(dw_b),
    .en(en_b), .addr_r(ar_b), .data_r(d2), .rd_valid(v2), .busy(b2));

  // per-instance views for the model and the compare process
  logic        in_rst [3];
  logic        in_we  [3];
  logic        in_en  [3];
  logic [4:0]  in_aw  [3];
  logic [4:0]  in_ar  [3];
  logic [63:0] in_dw  [3];
  logic [63:0] o_data [3];
  logic        o_valid[3];
  logic        o_busy [3];

  assign in_rst[0] = rst_a;          assign in_rst[1] = rst_a;          assign in_rst[2] = rst_b;
  assign in_we[0]  = we_a;           assign in_we[1]  = we_a;           assign in_we[2]  = we_b;
  assign in_en[0]  = en_a;           assign in_en[1]  = en_a;           assign in_en[2]  = en_b;
  assign in_aw[0]  = {2'b00, aw_a};  assign in_aw[1]  = {2'b00, aw_a};  assign in_aw[2]  = aw_b;
  assign in_ar[0]  = {2'b00, ar_a};  assign in_ar[1]  = {2'b00, ar_a};  assign in_ar[2]  = ar_b;
  assign in_dw[0]  = {48'd0, dw_a};  assign in_dw[1]  = {48'd0, dw_a};  assign in_dw[2]  = {32'd0, dw_b};
  assign o_data[0] = {48'd0, d0};    assign o_data[1] = {48'd0, d1};    assign o_data[2] = {32'd0, d2};
  assign o_valid[0] = v0;            assign o_valid[1] = v1;            assign o_valid[2] = v2;
  assign o_busy[0]  = b0;            assign o_busy[1]  = b1;            assign o_busy[2]  = b2;

  function automatic int m_depth(input int k);
    return (k == 2) ? 32 : 8;
  endfunction

  function automatic logic [63:0] m_init(input int k);
    return (k == 2) ? 64'h0000_0000_5A5A_0F0F : 64'h0000_0000_0000_A5A5;
  endfunction

  function automatic bit m_write_first(input int k);
    return (k != 1);
  endfunction

  // reference model: words to clear, memory array, expected outputs
  logic [63:0] m_mem  [3][32];
  logic [63:0] m_data [3];
  logic        m_valid[3];
  logic        m_busy [3];
  logic        m_known[3] = '{1'b0, 1'b0, 1'b0};
  int          m_left [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (in_rst[k]) begin
        m_data[k]  <= 64'd0;
        m_valid[k] <= 1'b0;
        m_busy[k]  <= 1'b1;
        m_left[k]  <= m_depth(k);
        m_known[k] <= 1'b1;
      end else if (m_busy[k]) begin
        m_valid[k] <= 1'b0;
        if (m_left[k] > 0) begin
          m_mem[k][m_depth(k) - m_left[k]] <= m_init(k);
          m_left[k] <= m_left[k] - 1;
          m_busy[k] <= (m_left[k] != 1);
        end
      end else begin
        if (in_en[k]) begin
          m_valid[k] <= 1'b1;
          if (m_write_first(k) && in_we[k] && (in_aw[k] == in_ar[k]))
            m_data[k] <= in_dw[k];
          else
            m_data[k] <= m_mem[k][in_ar[k]];
        end else begin
          m_valid[k] <= 1'b0;
        end
        if (in_we[k]) m_mem[k][in_aw[k]] <= in_dw[k];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // every-cycle compare of all three instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_known[k]) begin
        chk($sformatf("model_busy%0d", k),  {63'd0, o_busy[k]},  {63'd0, m_busy[k]});
        chk($sformatf("model_valid%0d", k), {63'd0, o_valid[k]}, {63'd0, m_valid[k]});
        chk($sformatf("model_data%0d", k),  o_data[k], m_data[k]);
      end
    end
  end

  // call on the negedge where rst has just been dropped; counts busy cycles
  task automatic count_busy(input int k, input int exp, input string nm);
    int n = 0;
    while (o_busy[k] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 64'(n), 64'(exp));
  endtask

  task automatic group_a();
    logic [15:0] ia = 16'hA5A5;
    rst_a = 1'b1; we_a = 1'b0; en_a = 1'b0; aw_a = 3'd0; ar_a = 3'd0; dw_a = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    count_busy(0, 8, "clear_len");
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1; ar_a = 3'(i);
      @(negedge clk);
      chk("init_read", {48'd0, d0}, {48'd0, ia});
      chk("init_valid", {63'd0, v0}, 64'd1);
    end
    en_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we_a = 1'b1; aw_a = 3'(i); dw_a = 16'h1000 + 16'(i);
      @(negedge clk);
    end
    we_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1; ar_a = 3'(i);
      @(negedge clk);
      chk("sweep_wf", {48'd0, d0}, 64'h1000 + 64'(i));
      chk("sweep_rf", {48'd0, d1}, 64'h1000 + 64'(i));
      chk("sweep_valid", {63'd0, v0}, 64'd1);
    end
    en_a = 1'b0;
    we_a = 1'b1; aw_a = 3'd3; dw_a = 16'h0033;
    @(negedge clk);
    en_a = 1'b1; ar_a = 3'd3; dw_a = 16'hBEEF;
    @(negedge clk);
    chk("coll_write_first", {48'd0, d0}, 64'hBEEF);
    chk("coll_read_first", {48'd0, d1}, 64'h0033);
    we_a = 1'b0;
    @(negedge clk);
    chk("coll_after_wf", {48'd0, d0}, 64'hBEEF);
    chk("coll_after_rf", {48'd0, d1}, 64'hBEEF);
    // requests held throughout a clear must be dropped
    en_a = 1'b1; ar_a = 3'd2; we_a = 1'b1; aw_a = 3'd2; dw_a = 16'h1234; rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    begin
      int n = 0;
      while (b0 && n < 100) begin
        chk("busy_rd_valid", {63'd0, v0}, 64'd0);
        n++;
        @(negedge clk);
      end
      chk("busy_len", 64'(n), 64'd8);
    end
    we_a = 1'b0; ar_a = 3'd2;
    @(negedge clk);
    chk("busy_write_dropped", {48'd0, d0}, {48'd0, ia});
    en_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we_a = 1'b1; aw_a = 3'(i); dw_a = 16'($urandom);
      @(negedge clk);
    end
    we_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_a = 1'b1; ar_a = 3'(i);
      @(negedge clk);
    end
    ar_a = 3'd3; rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", {48'd0, d0}, 64'd0);
    chk("mid_rst_valid", {63'd0, v0}, 64'd0);
    rst_a = 1'b0; en_a = 1'b0;
    count_busy(0, 8, "mid_rst_clear_len");
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1; ar_a = 3'(i);
      @(negedge clk);
      chk("mid_rst_reread", {48'd0, d0}, {48'd0, ia});
    end
    en_a = 1'b0;
    repeat (400) begin
      rst_a = ($urandom_range(0, 59) == 0);
      we_a  = 1'($urandom_range(0, 1));
      en_a  = 1'($urandom_range(0, 1));
      aw_a  = 3'($urandom);
      ar_a  = 3'($urandom);
      dw_a  = 16'($urandom);
      @(negedge clk);
    end
    rst_a = 1'b0; we_a = 1'b0; en_a = 1'b0;
  endtask

  task automatic group_b();
    logic [31:0] vals [32];
    rst_b = 1'b1; we_b = 1'b0; en_b = 1'b0; aw_b = 5'd0; ar_b = 5'd0; dw_b = 32'd0;
    @(negedge clk);
    rst_b = 1'b0;
    count_busy(2, 32, "wide_clear_len");
    for (int i = 0; i < 32; i++) begin
      vals[i] = $urandom;
      we_b = 1'b1; aw_b = 5'(i); dw_b = vals[i];
      @(negedge clk);
    end
    we_b = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      en_b = 1'b1; ar_b = 5'(i);
      @(negedge clk);
      chk("wide_reverse", {32'd0, d2}, {32'd0, vals[i]});
      chk("wide_valid", {63'd0, v2}, 64'd1);
    end
    en_b = 1'b0;
    repeat (400) begin
      rst_b = ($urandom_range(0, 99) == 0);
      we_b  = 1'($urandom_range(0, 1));
      en_b  = 1'($urandom_range(0, 1));
      aw_b  = 5'($urandom);
      ar_b  = 5'($urandom);
      dw_b  = $urandom;
      @(negedge clk);
    end
    rst_b = 1'b0; we_b = 1'b0; en_b = 1'b0;
  endtask

  initial begin
    fork
      group_a();
      group_b();
    join
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
